uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arb.sv | 128 ++++++++++++
 tb/tb_uart_tx_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter and the rx/tx
// cores. It holds the arbiter FSM state encoding and the default build
// constants.
// No ports (package).
package uart_pkg;

    localparam int N_REQ_DEFAULT        = 4;
    localparam int HOLD_TIMEOUT_DEFAULT = 64;
    localparam int HOLD_CNT_W           = 8;

    // Arbiter FSM states. They are plain 2-bit constants so that older
    // blocks, which compare raw state codes, can share the same values.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE      = 2'd0;
    localparam arb_state_t ST_LOAD      = 2'd1;
    localparam arb_state_t ST_WAIT_DONE = 2'd2;
    localparam arb_state_t ST_HOLD      = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// It returns the first set bit of 'valid', searching from index 'ptr' upward
// and wrapping from N-1 back to 0.
//   valid : request vector
//   ptr   : starting index of the search
//   idx   : selected index (0 when nothing is found)
//   found : high when any bit of 'valid' is set
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    // NOTE: assign every always_comb output a default before any branch.
    // A path that skips the assignment would infer a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && valid[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that lets N_REQ byte-stream requesters
// share one UART transmitter. Once a requester is granted a packet, it keeps
// the transmitter until it sends the byte marked 'last'. If the owner stays
// idle for HOLD_TIMEOUT cycles between bytes, the packet is aborted and the
// grant is released.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   req_valid  : per-requester byte valid
//   req_data   : per-requester byte; requester i uses bits [8i+7:8i]
//   req_last   : the byte is the last one of its packet
//   req_ready  : one-hot acknowledge of the byte, high only in LOAD
//   tx_start   : one-cycle start pulse to the transmitter
//   tx_data    : byte to transmit; held from tx_start until tx_done
//   tx_done    : one-cycle pulse from the transmitter when it is finished
//   grant_id   : index of the current owner
//   busy       : high in every state except IDLE
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEFAULT,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT,
    parameter int IDW          = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
);

    arb_state_t            state;
    logic [IDW-1:0]        rr_ptr;
    logic                  last_q;
    logic [HOLD_CNT_W-1:0] hold_cnt;

    logic [IDW-1:0]        pick_idx;
    logic                  pick_found;
    logic [IDW-1:0]        next_ptr;

    rr_pick #(
        .N (N_REQ),
        .W (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The pointer moves to the requester after the one that just finished.
    // It wraps explicitly, so N_REQ does not have to be a power of two.
    assign next_ptr = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

    // tx_start and req_ready are decoded from the state. They cannot outlive
    // LOAD, and the asynchronous reset clears them immediately.
    assign tx_start = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        req_ready = '0;
        if (state == ST_LOAD) req_ready[grant_id] = 1'b1;
    end

    // tx_data and last_q are captured on entry to LOAD. The byte is already
    // on tx_data in the cycle that tx_start fires, and it stays there until
    // the next LOAD.
    // NOTE: sequential state is written only with non-blocking assignments.
    // All registers read their old values in the same edge, so the order of
    // the statements does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_data  <= '0;
            last_q   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        tx_data  <= req_data[{pick_idx, 3'b000} +: 8];
                        last_q   <= req_last[pick_idx];
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        if (last_q) begin
                            rr_ptr <= next_ptr;
                            state  <= ST_IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Only the owner can continue. Other requesters wait
                    // until the packet ends or times out.
                    if (req_valid[grant_id]) begin
                        tx_data  <= req_data[{grant_id, 3'b000} +: 8];
                        last_q   <= req_last[grant_id];
                        hold_cnt <= '0;
                        state    <= ST_LOAD;
                    end else if (hold_cnt == HOLD_CNT_W'(HOLD_TIMEOUT - 1)) begin
                        hold_cnt <= '0;
                        rr_ptr   <= next_ptr;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb with its
// default parameters (4 requesters, hold timeout 64).
// The stimulus changes 1 time unit after each rising edge, and outputs are
// sampled at the same point.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    // Bounded wait for tx_start. An expired budget counts as a failed check.
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!tx_start && n < 50) begin
            tick;
            n++;
        end
        chk(tag, {31'd0, tx_start}, 32'd1);
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]     = v;
        req_data[8*i +: 8] = d;
        req_last[i]      = l;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_done   = 1'b0;
        tick;
        tick;

        // Reset state
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_ready",    {28'd0, req_ready}, 32'd0);
        chk("rst_grant",    {30'd0, grant_id}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
        rst_n = 1'b1;
        tick;

        // Single byte from requester 2
        set_req(2, 1'b1, 8'hA5, 1'b1);
        tick;
        chk("sb_tx_start", {31'd0, tx_start}, 32'd1);
        chk("sb_tx_data",  {24'd0, tx_data},  32'hA5);
        chk("sb_ready",    {28'd0, req_ready}, 32'h4);
        chk("sb_grant",    {30'd0, grant_id}, 32'd2);
        req_valid[2] = 1'b0;
        tick;
        chk("sb_start_1cyc", {31'd0, tx_start}, 32'd0);
        chk("sb_ready_off",  {28'd0, req_ready}, 32'd0);
        tick;
        tick;
        chk("sb_data_hold", {24'd0, tx_data}, 32'hA5);
        pulse_done;
        chk("sb_idle",   {31'd0, busy}, 32'd0);
        chk("sb_rr_ptr", {30'd0, dut.rr_ptr}, 32'd3);

        // Round-robin: all four requesters are continuously valid
        do_reset;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_start($sformatf("rr%0d_start", k));
            chk($sformatf("rr%0d_grant", k), {30'd0, grant_id}, 32'(k % 4));
            chk($sformatf("rr%0d_data", k),  {24'd0, tx_data},  32'(8'h10 + (k % 4)));
            chk($sformatf("rr%0d_ready", k), {28'd0, req_ready}, 32'(1 << (k % 4)));
            tick;
            tick;
            pulse_done;
        end
        req_valid = '0;
        // The last grant went to 0, so the pointer is now 1.
        tick;
        chk("rr_ptr_after", {30'd0, dut.rr_ptr}, 32'd1);

        // Packet lock: requester 1 sends three bytes while requester 0 waits
        set_req(0, 1'b1, 8'hEE, 1'b1);
        set_req(1, 1'b1, 8'h11, 1'b0);
        wait_start("pk_b1_start");
        chk("pk_b1_grant", {30'd0, grant_id}, 32'd1);
        chk("pk_b1_data",  {24'd0, tx_data},  32'h11);
        tick;
        set_req(1, 1'b1, 8'h22, 1'b0);
        pulse_done;
        chk("pk_hold_busy",  {31'd0, busy},     32'd1);
        chk("pk_hold_start", {31'd0, tx_start}, 32'd0);
        tick;
        chk("pk_b2_start", {31'd0, tx_start}, 32'd1);
        chk("pk_b2_grant", {30'd0, grant_id}, 32'd1);
        chk("pk_b2_data",  {24'd0, tx_data},  32'h22);
        chk("pk_b2_ready", {28'd0, req_ready}, 32'h2);
        tick;
        set_req(1, 1'b1, 8'h33, 1'b1);
        pulse_done;
        tick;
        chk("pk_b3_start", {31'd0, tx_start}, 32'd1);
        chk("pk_b3_data",  {24'd0, tx_data},  32'h33);
        chk("pk_b3_ready", {28'd0, req_ready}, 32'h2);
        tick;
        req_valid[1] = 1'b0;
        pulse_done;
        chk("pk_end_ptr", {30'd0, dut.rr_ptr}, 32'd2);
        tick;
        chk("pk_r0_start", {31'd0, tx_start}, 32'd1);
        chk("pk_r0_grant", {30'd0, grant_id}, 32'd0);
        chk("pk_r0_data",  {24'd0, tx_data},  32'hEE);
        tick;
        req_valid[0] = 1'b0;
        pulse_done;

        // Timeout: requester 3 sends a non-last byte and then goes quiet
        set_req(3, 1'b1, 8'h3C, 1'b0);
        wait_start("to_start");
        chk("to_grant", {30'd0, grant_id}, 32'd3);
        tick;
        req_valid[3] = 1'b0;
        set_req(0, 1'b1, 8'h0F, 1'b1);
        pulse_done;
        repeat (63) tick;
        chk("to_hold_63",  {31'd0, busy},     32'd1);
        chk("to_no_start", {31'd0, tx_start}, 32'd0);
        tick;
        chk("to_idle",     {31'd0, busy}, 32'd0);
        chk("to_ptr",      {30'd0, dut.rr_ptr}, 32'd0);
        tick;
        chk("to_r0_start", {31'd0, tx_start}, 32'd1);
        chk("to_r0_grant", {30'd0, grant_id}, 32'd0);
        chk("to_r0_data",  {24'd0, tx_data},  32'h0F);
        tick;
        req_valid[0] = 1'b0;
        pulse_done;

        // Wrap: move the pointer to 3, then requesters 0 and 3 both ask
        set_req(2, 1'b1, 8'h2B, 1'b1);
        wait_start("wr_r2_start");
        tick;
        req_valid[2] = 1'b0;
        pulse_done;
        chk("wr_ptr3", {30'd0, dut.rr_ptr}, 32'd3);
        set_req(0, 1'b1, 8'h01, 1'b1);
        set_req(3, 1'b1, 8'h03, 1'b1);
        wait_start("wr_start");
        chk("wr_grant3", {30'd0, grant_id}, 32'd3);
        chk("wr_data3",  {24'd0, tx_data},  32'h03);
        tick;
        req_valid[3] = 1'b0;
        pulse_done;
        chk("wr_ptr0", {30'd0, dut.rr_ptr}, 32'd0);
        tick;
        chk("wr_grant0", {30'd0, grant_id}, 32'd0);
        chk("wr_ready0", {28'd0, req_ready}, 32'h1);
        tick;
        req_valid[0] = 1'b0;
        pulse_done;

        // Stray tx_done in IDLE must have no effect
        pulse_done;
        chk("st_busy",  {31'd0, busy},     32'd0);
        chk("st_start", {31'd0, tx_start}, 32'd0);
        chk("st_ptr",   {30'd0, dut.rr_ptr}, 32'd1);
        tick;
        chk("st_busy2", {31'd0, busy}, 32'd0);

        // Reset in the middle of a packet
        set_req(1, 1'b1, 8'h77, 1'b1);
        wait_start("mr_start");
        tick;
        req_valid[1] = 1'b0;
        chk("mr_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy",  {31'd0, busy},     32'd0);
        chk("mr_data",  {24'd0, tx_data},  32'd0);
        chk("mr_grant", {30'd0, grant_id}, 32'd0);
        chk("mr_ready", {28'd0, req_ready}, 32'd0);
        chk("mr_start0", {31'd0, tx_start}, 32'd0);
        chk("mr_ptr",   {30'd0, dut.rr_ptr}, 32'd0);
        tick;
        rst_n = 1'b1;
        // With the pointer at 0 requester 0 wins; a pointer left at 1 would give 3.
        set_req(0, 1'b1, 8'hC0, 1'b1);
        set_req(3, 1'b1, 8'hC3, 1'b1);
        wait_start("mr_new_start");
        chk("mr_new_grant", {30'd0, grant_id}, 32'd0);
        chk("mr_new_data",  {24'd0, tx_data},  32'hC0);
        tick;
        req_valid = '0;
        pulse_done;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
